// File: rtl/compute_core_sequencer.sv
// Instruction issuer for the OpenNTT compute core: buffers instruction words in a FIFO and
// walks each one through the core's load / enable / wait / release handshake.
module compute_core_sequencer #(
    parameter int LOG_COMMAND = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT     = 1048576
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ins_valid,
    input  logic [31:0]                   ins_word,
    output logic                          ins_ready,
    input  logic [63:0]                   q_cfg,
    input  logic [63:0]                   mont_cfg,
    input  logic                          run,
    input  logic                          flush,
    output logic [LOG_COMMAND-1:0]        command_in,
    output logic                          command_we,
    output logic [31:0]                   dina2_ext,
    output logic [63:0]                   dina_ext,
    output logic [63:0]                   dina3_ext,
    input  logic                          done_ins_computation,
    output logic                          busy,
    output logic                          ins_done,
    output logic [15:0]                   done_count,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LOG_COMMAND-1:0] CMD_ENABLE = {1'b1, {(LOG_COMMAND-1){1'b0}}};
    localparam logic [LOG_COMMAND-1:0] CMD_HOLD   = {LOG_COMMAND{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic [31:0]              mem [FIFO_DEPTH];
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic [31:0]              wait_cnt;
    logic                     wait_clr;
    logic                     cmd_we_next;
    logic [LOG_COMMAND-1:0]   cmd_next;
    logic                     ins_done_next;
    logic                     timeout_hit;

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign ins_ready  = !rst && !fifo_full;
    assign push       = ins_valid && ins_ready && !flush;
    assign busy       = (state != S_IDLE);

    // FIFO pointers; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= ins_word;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        wait_clr      = 1'b0;
        cmd_we_next   = 1'b0;
        cmd_next      = CMD_HOLD;
        ins_done_next = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run && !fifo_empty) begin
                    pop         = 1'b1;
                    cmd_we_next = 1'b1;
                    state_next  = S_LOAD;
                end else begin
                    state_next  = S_IDLE;
                end
            end
            S_LOAD: begin
                cmd_we_next = 1'b1;
                cmd_next    = CMD_ENABLE;
                state_next  = S_START;
            end
            S_START: begin
                wait_clr   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // done may still be high from the previous instruction for two cycles
                if (wait_cnt >= 32'd2 && done_ins_computation) begin
                    ins_done_next = 1'b1;
                    cmd_we_next   = 1'b1;
                    wait_clr      = 1'b1;
                    state_next    = S_RELEASE;
                end else if (TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1)) begin
                    timeout_hit   = 1'b1;
                    cmd_we_next   = 1'b1;
                    wait_clr      = 1'b1;
                    state_next    = S_RELEASE;
                end else begin
                    state_next    = S_WAIT;
                end
            end
            S_RELEASE: begin
                if (wait_cnt[0]) begin
                    state_next  = S_IDLE;
                end else begin
                    cmd_we_next = 1'b1;
                    state_next  = S_RELEASE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register and the WAIT/RELEASE cycle counter (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 32'd0;
        end else begin
            state <= state_next;
            if (wait_clr) begin
                wait_cnt <= 32'd0;
            end else if (wait_cnt != 32'hFFFF_FFFF) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end

    // Registered core interface and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            command_we  <= 1'b0;
            command_in  <= CMD_HOLD;
            dina2_ext   <= 32'd0;
            dina_ext    <= 64'd0;
            dina3_ext   <= 64'd0;
            ins_done    <= 1'b0;
            done_count  <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            command_we <= cmd_we_next;
            command_in <= cmd_next;
            ins_done   <= ins_done_next;
            if (pop) begin
                dina2_ext <= mem[rd_ptr[AW-1:0]];
                dina_ext  <= q_cfg;
                dina3_ext <= mont_cfg;
            end
            if (ins_done_next) begin
                done_count <= done_count + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_compute_core_sequencer.sv
// Directed bench for compute_core_sequencer with a behavioural core model and an issue-order scoreboard.
module tb_compute_core_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic [31:0] ins_word = 32'd0;
    logic        ins_ready;
    logic [63:0] q_cfg = 64'd0;
    logic [63:0] mont_cfg = 64'd0;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  command_in;
    logic        command_we;
    logic [31:0] dina2_ext;
    logic [63:0] dina_ext;
    logic [63:0] dina3_ext;
    logic        done_ins_computation;
    logic        busy;
    logic        ins_done;
    logic [15:0] done_count;
    logic        timeout_err;
    logic [4:0]  fifo_level;

    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    logic        core_run = 1'b0;
    logic        core_never = 1'b0;
    int          core_cnt = 0;
    int          latency = 10;

    int total = 0;
    int bad = 0;
    int starts = 0;
    int zero_writes = 0;
    int done_pulses = 0;
    logic [31:0] exp_q[$];

    assign done_ins_computation = model_done | force_done;

    compute_core_sequencer #(.LOG_COMMAND(8), .FIFO_DEPTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_word(ins_word), .ins_ready(ins_ready),
        .q_cfg(q_cfg), .mont_cfg(mont_cfg), .run(run), .flush(flush),
        .command_in(command_in), .command_we(command_we), .dina2_ext(dina2_ext),
        .dina_ext(dina_ext), .dina3_ext(dina3_ext), .done_ins_computation(done_ins_computation),
        .busy(busy), .ins_done(ins_done), .done_count(done_count), .timeout_err(timeout_err),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: command 0 holds it in reset and drops done; enable starts a latency countdown.
    always @(negedge clk) begin
        if (rst) begin
            model_done = 1'b0;
            core_run = 1'b0;
            core_cnt = 0;
        end else if (command_we && command_in == 8'h00) begin
            model_done = 1'b0;
            core_run = 1'b0;
        end else if (command_we && command_in == 8'h80) begin
            core_run = 1'b1;
            core_cnt = 0;
        end else if (core_run && !core_never) begin
            core_cnt++;
            if (core_cnt >= latency) begin
                model_done = 1'b1;
                core_run = 1'b0;
            end
        end
    end

    // Scoreboard: each enable write must carry the next pushed word.
    always @(negedge clk) begin
        if (!rst) begin
            if (command_we && command_in == 8'h00) zero_writes++;
            if (command_we && command_in == 8'h80) begin
                starts++;
                check("issue_has_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("dina2_order", 64'(dina2_ext), 64'(exp_q.pop_front()));
            end
            if (ins_done) done_pulses++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        ins_valid = 1'b1;
        ins_word = w;
        if (ins_ready && !flush) exp_q.push_back(w);
        tick();
        ins_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!(command_we && command_in == 8'h80) && n < budget) begin
            tick();
            n++;
        end
        check("wait_start_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (done_pulses < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_pulses_in_budget", 64'(done_pulses >= target), 64'd1);
    endtask

    initial begin
        int zw0, st0, dp0, n;
        // reset state
        tick();
        check("rst_ins_ready", 64'(ins_ready), 64'd0);
        check("rst_command_we", 64'(command_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_done_count", 64'(done_count), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ins_ready", 64'(ins_ready), 64'd1);

        // three instructions, latency 10
        q_cfg = 64'h0000_0000_0C00_1001;
        mont_cfg = 64'h1234_5678_9ABC_DEF0;
        push(32'hA000_0001);
        push(32'hA000_0002);
        push(32'hA000_0003);
        check("three_level", 64'(fifo_level), 64'd3);
        zw0 = zero_writes;
        st0 = starts;
        run = 1'b1;
        tick();
        tick();
        check("busy_running", 64'(busy), 64'd1);
        wait_pulses(3, 200);
        run = 1'b0;
        repeat (4) tick();
        check("three_done_count", 64'(done_count), 64'd3);
        check("three_starts", 64'(starts - st0), 64'd3);
        check("three_zero_writes", 64'(zero_writes - zw0), 64'd9);
        check("three_pulses", 64'(done_pulses), 64'd3);
        check("dina_q", dina_ext, 64'h0000_0000_0C00_1001);
        check("dina3_mont", dina3_ext, 64'h1234_5678_9ABC_DEF0);
        q_cfg = 64'd7;
        tick();
        check("dina_held", dina_ext, 64'h0000_0000_0C00_1001);
        check("idle_after_three", 64'(busy), 64'd0);

        // fill beyond depth with run low
        for (int i = 0; i < 17; i++) begin
            if (i == 16) check("full_ins_ready", 64'(ins_ready), 64'd0);
            push(32'hB000_0000 + 32'(i));
        end
        check("full_level", 64'(fifo_level), 64'd16);
        run = 1'b1;
        wait_pulses(19, 600);
        run = 1'b0;
        repeat (4) tick();
        check("drain_level", 64'(fifo_level), 64'd0);
        check("drain_done_count", 64'(done_count), 64'd19);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        // stale done held high through START
        force_done = 1'b1;
        push(32'hC000_0001);
        run = 1'b1;
        wait_start(50);
        run = 1'b0;
        tick();
        check("stale_wait0", 64'(ins_done), 64'd0);
        tick();
        check("stale_wait1", 64'(ins_done), 64'd0);
        force_done = 1'b0;
        dp0 = done_pulses;
        n = 0;
        while (done_pulses == dp0 && n < 100) begin
            tick();
            n++;
        end
        check("stale_late_done", 64'(n >= 8 && n < 100), 64'd1);
        repeat (4) tick();
        check("stale_done_count", 64'(done_count), 64'd20);

        // timeout with a silent core
        core_never = 1'b1;
        push(32'hD000_0001);
        push(32'hD000_0002);
        run = 1'b1;
        wait_start(50);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycle", 64'(n), 64'd65);
        check("timeout_release_we", 64'(command_we), 64'd1);
        check("timeout_release_cmd", 64'(command_in), 64'd0);
        check("timeout_no_ins_done", 64'(ins_done), 64'd0);
        core_never = 1'b0;
        wait_pulses(21, 100);
        run = 1'b0;
        repeat (4) tick();
        check("timeout_next_done_count", 64'(done_count), 64'd21);
        check("timeout_sticky", 64'(timeout_err), 64'd1);

        // flush during WAIT
        latency = 30;
        for (int i = 0; i < 6; i++) push(32'hE000_0000 + 32'(i));
        run = 1'b1;
        wait_start(50);
        st0 = starts;
        tick();
        check("flush_pre_level", 64'(fifo_level), 64'd5);
        flush = 1'b1;
        push(32'hEEEE_EEEE);
        flush = 1'b0;
        exp_q.delete();
        check("flush_level", 64'(fifo_level), 64'd0);
        wait_pulses(22, 100);
        repeat (4) tick();
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_no_more_issue", 64'(starts - st0), 64'd0);
        check("flush_done_count", 64'(done_count), 64'd22);

        // async reset mid-WAIT
        push(32'hF000_0001);
        wait_start(50);
        run = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("arst_command_we", 64'(command_we), 64'd0);
        check("arst_command_in", 64'(command_in), 64'd0);
        check("arst_dina2", 64'(dina2_ext), 64'd0);
        check("arst_dina", dina_ext, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done_count", 64'(done_count), 64'd0);
        check("arst_timeout_err", 64'(timeout_err), 64'd0);
        check("arst_ins_ready", 64'(ins_ready), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_arst_done_count", 64'(done_count), 64'd0);
        check("post_arst_level", 64'(fifo_level), 64'd0);
        check("post_arst_ins_ready", 64'(ins_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
